// File: rtl/jacobi_sweep_scheduler_pkg.sv
// Shared constants and FSM state type for the Jacobi sweep scheduler.
// Index and address widths follow the default matrix dimension JACOBI_N.
package jacobi_sweep_scheduler_pkg;

    localparam int unsigned JACOBI_N          = 4;
    localparam int unsigned JACOBI_IDX_WIDTH  = $clog2(JACOBI_N);
    localparam int unsigned JACOBI_ADDR_WIDTH = $clog2(JACOBI_N * JACOBI_N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } jacobi_state_e;

endpackage

// File: rtl/jacobi_sweep_scheduler.sv
// Issues cyclic-by-row pivot pairs (p,q), one outstanding at a time, for up to
// num_sweeps_i sweeps. N must not exceed JACOBI_N, which sizes the index/address ports.
module jacobi_sweep_scheduler
    import jacobi_sweep_scheduler_pkg::*;
#(
    parameter int unsigned N       = JACOBI_N,
    parameter int unsigned SWEEP_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [SWEEP_W-1:0]           num_sweeps_i,
    input  logic                         abort_i,
    input  logic                         converged_i,
    output logic [JACOBI_IDX_WIDTH-1:0]  pair_p_o,
    output logic [JACOBI_IDX_WIDTH-1:0]  pair_q_o,
    output logic [JACOBI_ADDR_WIDTH-1:0] pair_addr_o,
    output logic                         pair_last_o,
    output logic                         pair_vld_o,
    input  logic                         pair_rdy_i,
    input  logic                         pair_done_i,
    output logic [SWEEP_W-1:0]           sweep_idx_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned IW = JACOBI_IDX_WIDTH;
    localparam int unsigned AW = JACOBI_ADDR_WIDTH;
    localparam logic [IW-1:0] LAST_P = IW'(N - 2);
    localparam logic [IW-1:0] LAST_Q = IW'(N - 1);

    jacobi_state_e      r_state;
    jacobi_state_e      w_next;
    logic [IW-1:0]      r_p;
    logic [IW-1:0]      r_q;
    logic [IW-1:0]      w_p;
    logic [IW-1:0]      w_q;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      w_addr;
    logic [SWEEP_W-1:0] r_sweep;
    logic [SWEEP_W-1:0] w_sweep;
    logic [SWEEP_W-1:0] r_num;
    logic [SWEEP_W-1:0] w_num;
    logic               w_final_sweep;
    logic               r_last;
    logic               r_vld;
    logic               r_busy;
    logic               r_done;

    // Next-state and next-pair logic; the address is tracked incrementally,
    // so p*N+q never needs a multiplier.
    always_comb begin
        w_next        = r_state;
        w_p           = r_p;
        w_q           = r_q;
        w_addr        = r_addr;
        w_sweep       = r_sweep;
        w_num         = r_num;
        w_final_sweep = ((r_sweep + SWEEP_W'(1)) == r_num);

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_num   = num_sweeps_i;
                    w_p     = '0;
                    w_q     = IW'(1);
                    w_addr  = AW'(1);
                    w_sweep = '0;
                    w_next  = (num_sweeps_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    w_next = ST_DONE;
                end else if (pair_rdy_i) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    w_next = ST_DONE;
                end else if (pair_done_i) begin
                    if (r_last) begin
                        if (converged_i || w_final_sweep) begin
                            w_next = ST_DONE;
                        end else begin
                            w_sweep = r_sweep + SWEEP_W'(1);
                            w_p     = '0;
                            w_q     = IW'(1);
                            w_addr  = AW'(1);
                            w_next  = ST_ISSUE;
                        end
                    end else if (r_q == LAST_Q) begin
                        // Row wrap: (p+1)*N + (p+2) = (p*N + N-1) + p + 3
                        w_p    = r_p + IW'(1);
                        w_q    = r_p + IW'(2);
                        w_addr = r_addr + AW'(r_p) + AW'(3);
                        w_next = ST_ISSUE;
                    end else begin
                        w_q    = r_q + IW'(1);
                        w_addr = r_addr + AW'(1);
                        w_next = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_p     <= '0;
            r_q     <= IW'(1);
            r_addr  <= AW'(1);
            r_sweep <= '0;
            r_num   <= '0;
            r_last  <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_p     <= w_p;
            r_q     <= w_q;
            r_addr  <= w_addr;
            r_sweep <= w_sweep;
            r_num   <= w_num;
            r_last  <= (w_p == LAST_P) && (w_q == LAST_Q);
            r_vld   <= (w_next == ST_ISSUE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (r_state == ST_DONE);
        end
    end

    assign pair_p_o    = r_p;
    assign pair_q_o    = r_q;
    assign pair_addr_o = r_addr;
    assign pair_last_o = r_last;
    assign pair_vld_o  = r_vld;
    assign sweep_idx_o = r_sweep;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule

// File: tb/tb_jacobi_sweep_scheduler.sv
// Directed self-checking bench for jacobi_sweep_scheduler at N=4.
// A small controller model accepts pairs and pulses pair_done_i 3 cycles later.
module tb_jacobi_sweep_scheduler;
    import jacobi_sweep_scheduler_pkg::*;

    localparam int unsigned SWEEP_W = 4;

    logic                         clk;
    logic                         rst;
    logic                         start_i;
    logic [SWEEP_W-1:0]           num_sweeps_i;
    logic                         abort_i;
    logic                         converged_i;
    logic [JACOBI_IDX_WIDTH-1:0]  pair_p_o;
    logic [JACOBI_IDX_WIDTH-1:0]  pair_q_o;
    logic [JACOBI_ADDR_WIDTH-1:0] pair_addr_o;
    logic                         pair_last_o;
    logic                         pair_vld_o;
    logic                         pair_rdy_i;
    logic                         pair_done_i;
    logic [SWEEP_W-1:0]           sweep_idx_o;
    logic                         busy_o;
    logic                         done_o;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    int exp_p[6]    = '{0, 0, 0, 1, 1, 2};
    int exp_q[6]    = '{1, 2, 3, 2, 3, 3};
    int exp_addr[6] = '{1, 2, 3, 6, 7, 11};

    jacobi_sweep_scheduler #(.N(4), .SWEEP_W(SWEEP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_sweeps_i (num_sweeps_i),
        .abort_i      (abort_i),
        .converged_i  (converged_i),
        .pair_p_o     (pair_p_o),
        .pair_q_o     (pair_q_o),
        .pair_addr_o  (pair_addr_o),
        .pair_last_o  (pair_last_o),
        .pair_vld_o   (pair_vld_o),
        .pair_rdy_i   (pair_rdy_i),
        .pair_done_i  (pair_done_i),
        .sweep_idx_o  (sweep_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && done_o) done_cnt++;
        if (rst && pair_vld_o && pair_rdy_i) hs_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Checks the presented pair, accepts it, then pulses pair_done_i 3 cycles after accept.
    task automatic do_pair(input int ep, input int eq, input int ea, input int el,
                           input int es, input logic conv);
        check("vld", int'(pair_vld_o), 1);
        check("p", int'(pair_p_o), ep);
        check("q", int'(pair_q_o), eq);
        check("addr", int'(pair_addr_o), ea);
        check("last", int'(pair_last_o), el);
        check("sweep", int'(sweep_idx_o), es);
        check("busy", int'(busy_o), 1);
        pair_rdy_i = 1'b1;
        cyc();
        check("vld_in_wait", int'(pair_vld_o), 0);
        cyc();
        cyc();
        pair_done_i = 1'b1;
        converged_i = conv;
        cyc();
        pair_done_i = 1'b0;
        converged_i = 1'b0;
    endtask

    task automatic run_sweep(input int first, input int s, input logic conv_end);
        for (int k = first; k < 6; k++) begin
            do_pair(exp_p[k], exp_q[k], exp_addr[k], (k == 5) ? 1 : 0, s,
                    conv_end && (k == 5));
        end
    endtask

    // Job has just entered DONE; expect one done_o pulse as busy_o drops.
    task automatic end_check(input string tag);
        check({tag, "_vld_off"}, int'(pair_vld_o), 0);
        check({tag, "_busy_in_done"}, int'(busy_o), 1);
        check({tag, "_done_early"}, int'(done_o), 0);
        cyc();
        check({tag, "_done_pulse"}, int'(done_o), 1);
        check({tag, "_busy_drop"}, int'(busy_o), 0);
        cyc();
        check({tag, "_done_clear"}, int'(done_o), 0);
    endtask

    task automatic start_job(input int ns);
        num_sweeps_i = SWEEP_W'(ns);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        start_i      = 1'b0;
        num_sweeps_i = '0;
        abort_i      = 1'b0;
        converged_i  = 1'b0;
        pair_rdy_i   = 1'b0;
        pair_done_i  = 1'b0;
        cyc();
        cyc();

        check("rst_vld", int'(pair_vld_o), 0);
        check("rst_p", int'(pair_p_o), 0);
        check("rst_q", int'(pair_q_o), 1);
        check("rst_addr", int'(pair_addr_o), 1);
        check("rst_last", int'(pair_last_o), 0);
        check("rst_sweep", int'(sweep_idx_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        rst = 1'b1;
        cyc();

        // One sweep, full pair order and addresses
        start_job(1);
        run_sweep(0, 0, 1'b0);
        end_check("t1");
        check("t1_done_cnt", done_cnt, 1);
        check("t1_hs_cnt", hs_cnt, 6);

        // Three-sweep limit, convergence reported at the end of sweep 1
        start_job(3);
        run_sweep(0, 0, 1'b0);
        run_sweep(0, 1, 1'b1);
        end_check("t2");
        check("t2_hs_cnt", hs_cnt, 18);

        // Backpressure on (0,2) plus a spurious pair_done_i while in ISSUE
        start_job(1);
        do_pair(0, 1, 1, 0, 0, 1'b0);
        pair_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pair_done_i = (i == 2);
            cyc();
            pair_done_i = 1'b0;
            check("bp_vld", int'(pair_vld_o), 1);
            check("bp_q", int'(pair_q_o), 2);
            check("bp_addr", int'(pair_addr_o), 2);
        end
        check("bp_hs_cnt", hs_cnt, 19);
        run_sweep(1, 0, 1'b0);
        end_check("t3");

        // Zero sweeps: straight to DONE; a start while busy is ignored
        start_job(0);
        check("z_vld", int'(pair_vld_o), 0);
        check("z_busy", int'(busy_o), 1);
        check("z_done_early", int'(done_o), 0);
        num_sweeps_i = SWEEP_W'(1);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        check("z_done", int'(done_o), 1);
        check("z_vld2", int'(pair_vld_o), 0);
        check("z_busy2", int'(busy_o), 0);
        cyc();
        check("z_ignored_vld", int'(pair_vld_o), 0);
        check("z_ignored_busy", int'(busy_o), 0);
        check("z_done_clear", int'(done_o), 0);
        check("z_done_cnt", done_cnt, 4);

        // Abort in WAIT of (1,2), colliding with pair_done_i; then restart
        start_job(1);
        for (int k = 0; k < 3; k++) begin
            do_pair(exp_p[k], exp_q[k], exp_addr[k], 0, 0, 1'b0);
        end
        check("ab_p", int'(pair_p_o), 1);
        check("ab_q", int'(pair_q_o), 2);
        pair_rdy_i = 1'b1;
        cyc();
        check("ab_wait_vld", int'(pair_vld_o), 0);
        abort_i = 1'b1;
        pair_done_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        pair_done_i = 1'b0;
        end_check("ab");
        check("ab_done_cnt", done_cnt, 5);
        start_job(1);
        check("rs_vld", int'(pair_vld_o), 1);
        check("rs_p", int'(pair_p_o), 0);
        check("rs_q", int'(pair_q_o), 1);
        check("rs_addr", int'(pair_addr_o), 1);
        check("rs_sweep", int'(sweep_idx_o), 0);

        // Reset while a pair is being offered
        pair_rdy_i = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        check("mr_vld", int'(pair_vld_o), 0);
        check("mr_p", int'(pair_p_o), 0);
        check("mr_q", int'(pair_q_o), 1);
        check("mr_addr", int'(pair_addr_o), 1);
        check("mr_last", int'(pair_last_o), 0);
        check("mr_busy", int'(busy_o), 0);
        check("mr_done", int'(done_o), 0);
        cyc();
        cyc();
        check("mr_no_done", int'(done_o), 0);
        check("mr_idle_vld", int'(pair_vld_o), 0);
        check("mr_done_cnt", done_cnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
